// File: rtl/wvb_reader.sv
// wvb_reader: read side of the mDOM waveform buffer.
// Takes the header at the FIFO head and reads waveform RAM from start to stop,
// wrapping modulo 2^P_ADR_WIDTH. Samples are streamed out on a valid/ready port
// through a 4-deep output FIFO. When the event is done, the header is popped and
// wvb_rddone pulses in the same cycle.
// Optional feature: define WVB_READER_HDR_WORD_EN to send a length word ahead of
// each event's samples.
module wvb_reader #(
   parameter int unsigned P_ADR_WIDTH  = 12,
   parameter int unsigned P_DATA_WIDTH = 22
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    hdr_empty,
   input  logic [P_ADR_WIDTH-1:0]  hdr_start,
   input  logic [P_ADR_WIDTH-1:0]  hdr_stop,
   output logic                    hdr_rdreq,
   output logic                    wvb_rd_en,
   output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
   input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
   output logic [P_DATA_WIDTH-1:0] dout,
   output logic                    dout_valid,
   output logic                    dout_last,
   input  logic                    dout_ready,
   output logic                    wvb_rddone,
   output logic                    busy
);

   localparam int unsigned ADR   = P_ADR_WIDTH;
   localparam int unsigned DW    = P_DATA_WIDTH;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned PND_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE,
      S_HOLD
   } state_t;

   state_t           state;
   logic [ADR-1:0]   rd_ptr;
   logic [ADR-1:0]   stop_reg;
   logic             rd_last;
   logic             dv;
   logic             dv_last;

   logic [DW:0]      fifo_mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [CNT_W-1:0] fifo_cnt;
   logic [DW:0]      head;
   logic             push;
   logic [DW:0]      push_word;
   logic             pop;
   logic [PND_W-1:0] pending;
   logic             credit_ok;
   logic             len_push;

`ifdef WVB_READER_HDR_WORD_EN
   logic [ADR-1:0]   span_c;
   logic [ADR:0]     len_c;
   logic [ADR:0]     len_reg;

   // The event length needs one bit more than an address, so that 2^ADR fits.
   assign span_c = hdr_stop - hdr_start;
   assign len_c  = {1'b0, span_c} + (ADR+1)'(1);
`else
   assign len_push = 1'b0;
`endif

   // The output stream comes from the FIFO head. dout and dout_last are forced to 0 when the FIFO is empty.
   assign head       = fifo_mem[rd_idx];
   assign dout_valid = (fifo_cnt != '0);
   assign dout       = dout_valid ? head[DW-1:0] : '0;
   assign dout_last  = dout_valid & head[DW];
   assign pop        = dout_valid & dout_ready;

   // Credit check. Words already in the FIFO, plus words still on their way to it,
   // less the word being popped, must be at most 2.
   // This leaves room for the next issue and keeps throughput at one word per clock.
   assign pending   = PND_W'(fifo_cnt) + PND_W'(len_push) + PND_W'(dv) + PND_W'(wvb_rd_en);
   assign credit_ok = (pending <= (PND_W'(2) + PND_W'(pop)));

   // Select the FIFO write source: returning RAM data, or the length word.
   always_comb begin
      push      = 1'b0;
      push_word = '0;
      if (dv) begin
         push      = 1'b1;
         push_word = {dv_last, wvb_rd_data};
      end
`ifdef WVB_READER_HDR_WORD_EN
      else if (len_push) begin
         push      = 1'b1;
         push_word = {1'b0, DW'(len_reg)};
      end
`endif
   end

   // Output FIFO storage.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_idx] <= push_word;
      end
   end

   // Output FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx   <= '0;
         rd_idx   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_idx <= wr_idx + IDX_W'(1);
         end
         if (pop) begin
            rd_idx <= rd_idx + IDX_W'(1);
         end
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // RAM data is valid one cycle after the strobe, so delay the strobe and the last tag to match it.
   always_ff @(posedge clk) begin
      if (rst) begin
         dv      <= 1'b0;
         dv_last <= 1'b0;
      end else begin
         dv      <= wvb_rd_en;
         dv_last <= rd_last;
      end
   end

   // Readout FSM: start, issue reads, drain, pop the header, settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rd_ptr      <= '0;
         stop_reg    <= '0;
         wvb_rd_en   <= 1'b0;
         wvb_rd_addr <= '0;
         rd_last     <= 1'b0;
         hdr_rdreq   <= 1'b0;
         wvb_rddone  <= 1'b0;
         busy        <= 1'b0;
`ifdef WVB_READER_HDR_WORD_EN
         len_push    <= 1'b0;
         len_reg     <= '0;
`endif
      end else begin
         wvb_rd_en  <= 1'b0;
         rd_last    <= 1'b0;
         hdr_rdreq  <= 1'b0;
         wvb_rddone <= 1'b0;
`ifdef WVB_READER_HDR_WORD_EN
         len_push   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (en && !hdr_empty) begin
                  // The first read needs no credit check because the FIFO is empty between events.
                  stop_reg    <= hdr_stop;
                  wvb_rd_en   <= 1'b1;
                  wvb_rd_addr <= hdr_start;
                  rd_last     <= (hdr_start == hdr_stop);
                  rd_ptr      <= hdr_start + ADR'(1);
                  busy        <= 1'b1;
                  state       <= (hdr_start == hdr_stop) ? S_DRAIN : S_READ;
`ifdef WVB_READER_HDR_WORD_EN
                  len_push    <= 1'b1;
                  len_reg     <= len_c;
`endif
               end
            end
            S_READ: begin
               if (credit_ok) begin
                  wvb_rd_en   <= 1'b1;
                  wvb_rd_addr <= rd_ptr;
                  rd_last     <= (rd_ptr == stop_reg);
                  rd_ptr      <= rd_ptr + ADR'(1);
                  if (rd_ptr == stop_reg) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && dout_last) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               hdr_rdreq  <= 1'b1;
               wvb_rddone <= 1'b1;
               state      <= S_HOLD;
            end
            S_HOLD: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wvb_reader.sv
// Testbench for wvb_reader, with a header FIFO model, a RAM model and a scoreboard of expected words.
module tb_wvb_reader;

   localparam int ADR = 12;
   localparam int DW  = 22;
`ifdef WVB_READER_HDR_WORD_EN
   localparam int HDRW = 1;
`else
   localparam int HDRW = 0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic           hdr_empty;
   logic [ADR-1:0] hdr_start;
   logic [ADR-1:0] hdr_stop;
   logic           hdr_rdreq;
   logic           wvb_rd_en;
   logic [ADR-1:0] wvb_rd_addr;
   logic [DW-1:0]  wvb_rd_data;
   logic [DW-1:0]  dout;
   logic           dout_valid;
   logic           dout_last;
   logic           dout_ready;
   logic           wvb_rddone;
   logic           busy;

   wvb_reader #(.P_ADR_WIDTH(ADR), .P_DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty),
      .hdr_start(hdr_start), .hdr_stop(hdr_stop), .hdr_rdreq(hdr_rdreq),
      .wvb_rd_en(wvb_rd_en), .wvb_rd_addr(wvb_rd_addr), .wvb_rd_data(wvb_rd_data),
      .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
      .dout_ready(dout_ready), .wvb_rddone(wvb_rddone), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vec_n = 0;
   int err_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Header FIFO model (show-ahead)
   logic [ADR-1:0] hs_arr [64];
   logic [ADR-1:0] he_arr [64];
   int h_wr = 0;
   int h_rd = 0;
   assign hdr_empty = (h_wr == h_rd);
   assign hdr_start = hs_arr[h_rd[5:0]];
   assign hdr_stop  = he_arr[h_rd[5:0]];
   always @(posedge clk) if (hdr_rdreq) h_rd <= h_rd + 1;

   task automatic push_hdr(input logic [ADR-1:0] s, input logic [ADR-1:0] e);
      hs_arr[h_wr[5:0]] = s;
      he_arr[h_wr[5:0]] = e;
      h_wr = h_wr + 1;
   endtask

   // RAM model: data = {salt, addr}; returns garbage when no read was issued
   logic [9:0] salt = '0;
   function automatic logic [DW-1:0] ram_f(input logic [ADR-1:0] a);
      return (DW'(salt) << ADR) | DW'(a);
   endfunction
   always @(posedge clk) wvb_rd_data <= wvb_rd_en ? ram_f(wvb_rd_addr) : DW'($urandom);

   // Scoreboard: the expected {last, data} words, in order
   logic [DW:0] exp_q [$];
   function automatic int add_exp(input logic [ADR-1:0] s, input logic [ADR-1:0] e);
      int n;
      logic [ADR-1:0] a;
      n = (int'(e) - int'(s) + 4096) % 4096 + 1;
      if (HDRW == 1) exp_q.push_back({1'b0, DW'(n)});
      for (int k = 0; k < n; k++) begin
         a = ADR'(int'(s) + k);
         exp_q.push_back({(k == n - 1), ram_f(a)});
      end
      return n;
   endfunction

   // Ready driver
   int ready_mode = 0;
   int rphase = 0;
   initial begin
      dout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'($urandom_range(0, 1));
            default: begin
               dout_ready = (rphase == 0 || rphase == 3);
               rphase = (rphase + 1) % 4;
            end
         endcase
      end
   end

   // Output monitor
   int xfer_cnt = 0, rdreq_cnt = 0, last_cnt = 0, rdreq_cyc = 0;
   logic [DW-1:0] last_data;
   int rise_q [$];
   int lastx_q [$];
   logic prev_valid = 1'b0, prev_ready = 1'b0;
   logic [DW-1:0] prev_dout;
   logic [DW:0] e_w;
   always @(negedge clk) begin
      if (dout_valid && !prev_valid) rise_q.push_back(cyc);
      if (prev_valid && !prev_ready) begin
         chk("stall_valid", 32'(dout_valid), 32'd1);
         chk("stall_data", 32'(dout), 32'(prev_dout));
      end
      if (dout_valid && dout_ready) begin
         xfer_cnt++;
         if (exp_q.size() == 0) begin
            vec_n++;
            err_n++;
            $display("FAIL extra_word: got 0x%0h expected no word (cycle %0d)", dout, cyc);
         end else begin
            e_w = exp_q.pop_front();
            chk("dout", 32'(dout), 32'(e_w[DW-1:0]));
            chk("dout_last", 32'(dout_last), 32'(e_w[DW]));
         end
         if (dout_last) begin
            last_cnt++;
            last_data = dout;
            lastx_q.push_back(cyc);
         end
      end
      if (hdr_rdreq || wvb_rddone) begin
         chk("rddone_pair", 32'(wvb_rddone), 32'(hdr_rdreq));
         chk("pop_nonempty", 32'(hdr_empty), 32'd0);
      end
      if (hdr_rdreq) begin
         rdreq_cnt++;
         rdreq_cyc = cyc;
      end
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_dout  = dout;
   end

   task automatic wait_rdreq(input int target, input int budget);
      for (int i = 0; i < budget && rdreq_cnt < target; i++) begin
         @(negedge clk); #1;
      end
      chk("rdreq_wait", 32'(rdreq_cnt >= target), 32'd1);
   endtask

   task automatic drv_tick();
      @(posedge clk); #1;
   endtask

   task automatic obs_tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
      end
   endtask

   typedef struct {
      logic [ADR-1:0] start;
      logic [ADR-1:0] stop;
      int rmode;
      int en_pulse;
      int exp_words;
   } vec_t;

   task automatic run_event(input vec_t v);
      int x0, r0, l0, n;
      drv_tick();
      ready_mode = v.rmode;
      salt = 10'($urandom);
      x0 = xfer_cnt; r0 = rdreq_cnt; l0 = last_cnt;
      n = add_exp(v.start, v.stop);
      push_hdr(v.start, v.stop);
      en = 1'b1;
      if (v.en_pulse != 0) begin
         drv_tick(); drv_tick();
         en = 1'b0;
      end
      wait_rdreq(r0 + 1, 3 * v.exp_words + 60);
      obs_tick(4);
      chk("xfer_count", 32'(xfer_cnt - x0), 32'(v.exp_words + HDRW));
      chk("rdreq_count", 32'(rdreq_cnt - r0), 32'd1);
      chk("last_count", 32'(last_cnt - l0), 32'd1);
      chk("last_data", 32'(last_data), 32'(ram_f(v.stop)));
      chk("exp_empty", 32'(exp_q.size()), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   vec_t tbl [$];
   int c0, r0, x0, x1, n, len;
   logic [ADR-1:0] s_r;

   initial begin
      tbl.push_back('{12'h010, 12'h013, 0, 0, 4});
      tbl.push_back('{12'hFFE, 12'h001, 0, 0, 4});
      tbl.push_back('{12'h123, 12'h123, 0, 0, 1});
      tbl.push_back('{12'h200, 12'h209, 2, 0, 10});
      tbl.push_back('{12'h7F0, 12'h80F, 1, 1, 32});
      tbl.push_back('{12'hFFF, 12'h000, 2, 1, 2});
      tbl.push_back('{12'h005, 12'h004, 0, 0, 4096});
      for (int i = 0; i < 12; i++) begin
         s_r = ADR'($urandom_range(0, 4095));
         len = int'($urandom_range(1, 40));
         tbl.push_back('{s_r, ADR'(int'(s_r) + len - 1), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 1)), len});
      end

      // Reset state
      rst = 1'b1; en = 1'b0;
      repeat (3) drv_tick();
      obs_tick(1);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_last", 32'(dout_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(wvb_rd_en), 32'd0);
      chk("rst_rdreq", 32'(hdr_rdreq), 32'd0);
      chk("rst_rddone", 32'(wvb_rddone), 32'd0);
      drv_tick();
      rst = 1'b0;

      // Case 1 with exact timing, data = addr
      drv_tick();
      salt = '0; ready_mode = 0;
      rise_q.delete(); lastx_q.delete();
      r0 = rdreq_cnt; x0 = xfer_cnt;
      n = add_exp(12'h010, 12'h013);
      push_hdr(12'h010, 12'h013);
      obs_tick(3);
      chk("no_start_without_en", 32'(busy), 32'd0);
      drv_tick();
      en = 1'b1;
      c0 = cyc;
      obs_tick(2);
      chk("t1_rd_en", 32'(wvb_rd_en), 32'd1);
      chk("t1_rd_addr", 32'(wvb_rd_addr), 32'h010);
      wait_rdreq(r0 + 1, 40);
      obs_tick(3);
      if (rise_q.size() > 0) chk("first_valid_lat", 32'(rise_q[0] - c0), 32'(3 - HDRW));
      else chk("first_valid_seen", 32'(rise_q.size()), 32'd1);
      if (lastx_q.size() > 0) chk("rdreq_after_last", 32'(rdreq_cyc - lastx_q[lastx_q.size()-1]), 32'd2);
      else chk("last_seen", 32'(lastx_q.size()), 32'd1);
      chk("c1_xfers", 32'(xfer_cnt - x0), 32'(4 + HDRW));
      chk("c1_rdreq", 32'(rdreq_cnt - r0), 32'd1);

      // Table of events (fixed corner cases plus random ones)
      foreach (tbl[i]) run_event(tbl[i]);

      // Two headers queued back to back, with the gap between events measured
      drv_tick();
      en = 1'b0; ready_mode = 0; salt = 10'($urandom);
      rise_q.delete(); lastx_q.delete();
      r0 = rdreq_cnt;
      n = add_exp(12'h300, 12'h304);
      n = add_exp(12'h0A0, 12'h0A7);
      push_hdr(12'h300, 12'h304);
      push_hdr(12'h0A0, 12'h0A7);
      drv_tick();
      en = 1'b1;
      wait_rdreq(r0 + 2, 120);
      obs_tick(4);
      chk("q2_rdreq", 32'(rdreq_cnt - r0), 32'd2);
      chk("q2_rises", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() >= 2 && lastx_q.size() >= 1)
         chk("q2_gap", 32'(rise_q[1] - lastx_q[0]), 32'(6 - HDRW));
      chk("q2_exp_empty", 32'(exp_q.size()), 32'd0);

      // Reset partway through an event; the same header must then be read again in full
      drv_tick();
      en = 1'b0; ready_mode = 0; salt = 10'($urandom);
      r0 = rdreq_cnt;
      n = add_exp(12'h400, 12'h407);
      push_hdr(12'h400, 12'h407);
      drv_tick();
      en = 1'b1;
      x0 = xfer_cnt;
      for (int i = 0; i < 50 && (xfer_cnt - x0) < 3; i++) obs_tick(1);
      chk("pre_reset_words", 32'((xfer_cnt - x0) >= 3), 32'd1);
      drv_tick();
      rst = 1'b1;
      drv_tick();
      obs_tick(1);
      chk("mid_rst_valid", 32'(dout_valid), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rd_en", 32'(wvb_rd_en), 32'd0);
      chk("mid_rst_rd_addr", 32'(wvb_rd_addr), 32'd0);
      chk("mid_rst_rdreq_cnt", 32'(rdreq_cnt - r0), 32'd0);
      exp_q.delete();
      n = add_exp(12'h400, 12'h407);
      x1 = xfer_cnt;
      drv_tick();
      rst = 1'b0;
      wait_rdreq(r0 + 1, 100);
      obs_tick(4);
      chk("reread_xfers", 32'(xfer_cnt - x1), 32'(8 + HDRW));
      chk("reread_rdreq", 32'(rdreq_cnt - r0), 32'd1);
      chk("reread_exp_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end

endmodule
